// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and defaults for the FIFO write arbiter slice.
//   arb_state_e    : arbiter FSM state (IDLE while arbitrating, LOCKED while a
//                    burst owner holds the write port)
//   DEFAULT_*      : default parameter values used by the interface and top
//   idx_width()    : width of an index into an N-entry requester vector
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEFAULT_N_REQ     = 4;
  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_MAX_BURST = 8;
  localparam int DEFAULT_TIMEOUT   = 16;

  // Index width for an n-entry vector; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the requester handshake and FIFO write port of the arbiter.
//   req_valid_i  : per-requester beat valid
//   req_last_i   : per-requester last beat of burst
//   req_data_i   : packed data, requester k at [k*WIDTH +: WIDTH]
//   req_ready_o  : beat accepted this cycle (one-hot or zero)
//   fifo_full_i  : FIFO full flag
//   fifo_wr_en_o : FIFO write enable
//   fifo_wdata_o : FIFO write data
//   grant_o      : current owner, one-hot or zero
//   locked_o     : arbiter is holding a burst lock
//   abort_o      : one-cycle pulse when a lock is released by timeout
// Modports: master = arbiter side, slave = requesters/FIFO side.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_last_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   fifo_full_i;
  logic                   fifo_wr_en_o;
  logic [WIDTH-1:0]       fifo_wdata_o;
  logic [N_REQ-1:0]       grant_o;
  logic                   locked_o;
  logic                   abort_o;

  modport master (
    input  req_valid_i,
    input  req_last_i,
    input  req_data_i,
    input  fifo_full_i,
    output req_ready_o,
    output fifo_wr_en_o,
    output fifo_wdata_o,
    output grant_o,
    output locked_o,
    output abort_o
  );

  modport slave (
    output req_valid_i,
    output req_last_i,
    output req_data_i,
    output fifo_full_i,
    input  req_ready_o,
    input  fifo_wr_en_o,
    input  fifo_wdata_o,
    input  grant_o,
    input  locked_o,
    input  abort_o
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker.
//   req_i       : request vector
//   rr_last_i   : index of the previous winner; scanning starts just after it
//   grant_oh_o  : one-hot winner (zero when no request)
//   grant_idx_o : binary index of the winner (zero when no request)
//   found_o     : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_last_i,
  output logic [N_REQ-1:0] grant_oh_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             found_o
);

  logic [N_REQ-1:0] oh;
  logic [IDX_W-1:0] idx;
  logic             found;
  int               cand;

  // Walk the N_REQ positions starting at rr_last+1 with wrap; the first
  // requester seen wins. The previous winner is visited last.
  always_comb begin
    oh    = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(rr_last_i) + i) % N_REQ;
      if (!found && req_i[cand]) begin
        found    = 1'b1;
        idx      = IDX_W'(cand);
        oh[cand] = 1'b1;
      end
    end
    grant_oh_o  = oh;
    grant_idx_o = idx;
    found_o     = found;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin write arbiter sharing one synchronous FIFO write port among
// N_REQ requesters, with burst lock, MAX_BURST beat limit and a stall
// timeout that releases a lock whose owner goes quiet.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : fifo_wr_arbiter_if.master (requester handshake, FIFO write
//            port, grant/locked/abort status)
// Grant, ready, write enable and write data are combinational from the
// current requests and the registered state (zero-latency data path).
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEFAULT_N_REQ,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  fifo_wr_arbiter_if.master   bus
);

  localparam int IDX_W  = idx_width(N_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_last_q, rr_last_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  logic [IDX_W-1:0]  win_idx;
  logic [N_REQ-1:0]  win_oh;
  logic              have_win;
  logic              win_valid;
  logic              win_last;
  logic [WIDTH-1:0]  win_data;
  logic              xfer;
  logic              timeout_hit;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i       (bus.req_valid_i),
    .rr_last_i   (rr_last_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .found_o     (pick_found)
  );

  // Winner selection and data mux. While locked the registered owner is the
  // winner regardless of its valid, so the other requesters never see ready.
  always_comb begin
    win_idx  = pick_idx;
    win_oh   = pick_oh;
    have_win = pick_found;
    if (state_q == LOCKED) begin
      win_idx  = owner_q;
      win_oh   = N_REQ'(1) << owner_q;
      have_win = 1'b1;
    end
    win_valid = have_win & bus.req_valid_i[win_idx];
    win_last  = bus.req_last_i[win_idx];
    win_data  = have_win ? bus.req_data_i[int'(win_idx)*WIDTH +: WIDTH] : '0;
    xfer      = win_valid & ~bus.fifo_full_i;
  end

  assign bus.fifo_wr_en_o = xfer;
  assign bus.fifo_wdata_o = win_data;
  assign bus.grant_o      = have_win ? win_oh : '0;
  assign bus.req_ready_o  = xfer ? win_oh : '0;
  assign bus.locked_o     = (state_q == LOCKED);
  assign bus.abort_o      = timeout_hit;

  // Next-state logic. A full FIFO with the owner still valid holds every
  // counter, so backpressure alone can never trigger the timeout.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    timeout_hit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          rr_last_d = win_idx;
          if (!win_last && (MAX_BURST > 1)) begin
            state_d    = LOCKED;
            owner_d    = win_idx;
            beat_cnt_d = BEAT_W'(1);
            idle_cnt_d = '0;
          end
        end
      end

      LOCKED: begin
        if (xfer) begin
          idle_cnt_d = '0;
          if (win_last || (beat_cnt_q + BEAT_W'(1) == BEAT_W'(MAX_BURST))) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end else if (!win_valid) begin
          if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
            state_d     = IDLE;
            timeout_hit = 1'b1;
            beat_cnt_d  = '0;
            idle_cnt_d  = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. rr_last resets to the top index so requester 0 wins
  // the first arbitration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_last_q  <= IDX_W'(N_REQ - 1);
      owner_q    <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed, table-driven bench for fifo_wr_arbiter (N_REQ=4, WIDTH=8,
// MAX_BURST=8, TIMEOUT=16). Requester k always presents a fixed data byte
// so the expected write data follows from the expected grant.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [3:0] exp_grant;
    logic       exp_wr;
    logic       exp_locked;
    logic       exp_abort;
  } vec_t;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  vec_t vecs[$];

  fifo_wr_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  fifo_wr_arbiter #(
    .N_REQ     (4),
    .WIDTH     (8),
    .MAX_BURST (8),
    .TIMEOUT   (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  // Fixed per-requester data bytes.
  function automatic logic [7:0] dataFor(input logic [3:0] oh);
    case (oh)
      4'b0001: return 8'hA0;
      4'b0010: return 8'hB1;
      4'b0100: return 8'hC2;
      4'b1000: return 8'hD3;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void addVec(input logic [3:0] valid, input logic [3:0] last,
                                 input logic full, input logic [3:0] exp_grant,
                                 input logic exp_wr, input logic exp_locked,
                                 input logic exp_abort);
    vec_t v;
    v.valid      = valid;
    v.last       = last;
    v.full       = full;
    v.exp_grant  = exp_grant;
    v.exp_wr     = exp_wr;
    v.exp_locked = exp_locked;
    v.exp_abort  = exp_abort;
    vecs.push_back(v);
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last, input logic full);
    bus.req_valid_i = valid;
    bus.req_last_i  = last;
    bus.fifo_full_i = full;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_grant, input logic exp_wr,
                             input logic exp_locked, input logic exp_abort);
    checkEq({name, "_grant"},  32'(bus.grant_o),      32'(exp_grant));
    checkEq({name, "_ready"},  32'(bus.req_ready_o),  32'(exp_wr ? exp_grant : 4'b0000));
    checkEq({name, "_wr_en"},  32'(bus.fifo_wr_en_o), 32'(exp_wr));
    checkEq({name, "_wdata"},  32'(bus.fifo_wdata_o), 32'(dataFor(exp_grant)));
    checkEq({name, "_locked"}, 32'(bus.locked_o),     32'(exp_locked));
    checkEq({name, "_abort"},  32'(bus.abort_o),      32'(exp_abort));
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    pass_cnt  = 0;
    total_cnt = 0;
    bus.req_data_i = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // Round robin with single-beat transfers: 0,1,2,3,0.
    addVec(4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    addVec(4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    addVec(4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
    addVec(4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    addVec(4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    // Single beat from 1 so requester 2 is next in line.
    addVec(4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    // 3-beat burst from 2 with 1 also valid, then 1 wins.
    addVec(4'b0110, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
    addVec(4'b0110, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
    addVec(4'b0110, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
    addVec(4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    // Requester 0 never sets last: MAX_BURST=8 beats, then 1 wins.
    addVec(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) addVec(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0);
    addVec(4'b0011, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    // Winner with a full FIFO in IDLE: no write, no lock.
    addVec(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
    addVec(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
    // Lock requester 3, then it goes quiet while 0 asks: abort on 16th idle cycle.
    addVec(4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      addVec(4'b0001, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, (i == 15) ? 1'b1 : 1'b0);
    addVec(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    // Lock requester 1, FIFO full for 20 cycles: no write, no abort, then resume.
    addVec(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) addVec(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0);
    addVec(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0);
    addVec(4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0);
    addVec(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset state.
    #12;
    checkOutput("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].full);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_wr,
                  vecs[i].exp_locked, vecs[i].exp_abort);
      @(posedge clk);
      #1;
    end

    // Reset mid-burst: lock requester 2, reset, then 4'b0110 grants 1 first.
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("mid_beat1", 4'b0100, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("mid_beat2", 4'b0100, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0110, 4'b0110, 1'b0);
    #1;
    checkOutput("post_reset1", 4'b0010, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("post_reset2", 4'b0100, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
